// File: rtl/id_scoreboard_ctrl_pkg.sv
// Shared types and constants for the decode-stage GPR scoreboard.
// The optional macro SCBD_WB_BYPASS_EN is consumed by id_scoreboard_ctrl.
package id_scoreboard_ctrl_pkg;

    localparam int unsigned GPR_AW     = 5;
    localparam int unsigned NREG_DEF   = 32;
    localparam int unsigned CNT_W_DEF  = 2;
    localparam int unsigned PERF_W_DEF = 32;

    localparam logic [GPR_AW-1:0] R0 = '0;

    typedef enum logic [1:0] {
        OP_HOLD,
        OP_CLEAR,
        OP_INC,
        OP_DEC
    } cnt_op_e;

    // Operand/destination view of the decode-stage instruction.
    typedef struct packed {
        logic              valid;
        logic              src1_re;
        logic [GPR_AW-1:0] src1;
        logic              src2_re;
        logic [GPR_AW-1:0] src2;
        logic              dest_we;
        logic [GPR_AW-1:0] dest;
    } ds_hazard_t;

    localparam int unsigned HZ_BUS_W = $bits(ds_hazard_t);

    function automatic logic is_tracked(input logic [GPR_AW-1:0] addr);
        return addr != R0;
    endfunction

endpackage

// File: rtl/id_scoreboard_ctrl_scbd_cnt_cell.sv
// Per-register pending-write counter: saturating up/down with clear.
// err flags a would-be overflow or underflow in the current cycle.
module scbd_cnt_cell
    import id_scoreboard_ctrl_pkg::*;
#(
    parameter int unsigned CNT_W     = CNT_W_DEF,
    parameter bit          WB_BYPASS = 1'b0
) (
    input  logic clk,
    input  logic reset,
    input  logic clear,
    input  logic inc,
    input  logic dec,
    output logic busy,
    output logic busy_rd,
    output logic full,
    output logic err
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] CNT_ONE = CNT_W'(1);

    logic [CNT_W-1:0] cnt;
    cnt_op_e          op;

    // A simultaneous inc and dec cancel out, even at either bound.
    always_comb begin
        op  = OP_HOLD;
        err = 1'b0;
        if (clear) begin
            op = OP_CLEAR;
        end else if (inc && !dec) begin
            if (cnt == CNT_MAX) err = 1'b1;
            else                op  = OP_INC;
        end else if (dec && !inc) begin
            if (cnt == '0) err = 1'b1;
            else           op  = OP_DEC;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else begin
            case (op)
                OP_CLEAR: cnt <= '0;
                OP_INC:   cnt <= cnt + CNT_ONE;
                OP_DEC:   cnt <= cnt - CNT_ONE;
                default:  cnt <= cnt;
            endcase
        end
    end

    assign busy    = cnt != '0;
    assign full    = cnt == CNT_MAX;
    // With bypass, the last pending write retiring now no longer blocks readers.
    assign busy_rd = busy && !(WB_BYPASS && dec && cnt == CNT_ONE);

endmodule

// File: rtl/id_scoreboard_ctrl.sv
// Decode-stage register-hazard scoreboard: stall/issue, flush, stall counter.
// Define SCBD_WB_BYPASS_EN to let a retiring last writer unblock same-cycle readers.
module id_scoreboard_ctrl
    import id_scoreboard_ctrl_pkg::*;
#(
    parameter int unsigned NREG   = NREG_DEF,
    parameter int unsigned CNT_W  = CNT_W_DEF,
    parameter int unsigned PERF_W = PERF_W_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              ds_valid,
    input  logic              ds_src1_re,
    input  logic [GPR_AW-1:0] ds_src1,
    input  logic              ds_src2_re,
    input  logic [GPR_AW-1:0] ds_src2,
    input  logic              ds_dest_we,
    input  logic [GPR_AW-1:0] ds_dest,
    input  logic              es_allowin,
    input  logic              ws_rf_we,
    input  logic [GPR_AW-1:0] ws_rf_waddr,
    input  logic              pipe_flush,
    output logic              ds_stall,
    output logic              ds_issue,
    output logic [NREG-1:0]   busy_regs,
    output logic              scbd_err,
    output logic [PERF_W-1:0] stall_cycles
);

`ifdef SCBD_WB_BYPASS_EN
    localparam bit WB_BYPASS = 1'b1;
`else
    localparam bit WB_BYPASS = 1'b0;
`endif

    ds_hazard_t hz;
    logic [NREG-1:0] busy_vec;
    logic [NREG-1:0] busy_rd_vec;
    logic [NREG-1:0] full_vec;
    logic [NREG-1:0] err_vec;
    logic [NREG-1:0] inc_vec;
    logic [NREG-1:0] dec_vec;

    logic flush_d;
    logic inc_any;
    logic dec_any;
    logic src1_busy;
    logic src2_busy;
    logic waw_full;

    assign hz = '{
        valid:   ds_valid,
        src1_re: ds_src1_re,
        src1:    ds_src1,
        src2_re: ds_src2_re,
        src2:    ds_src2,
        dest_we: ds_dest_we,
        dest:    ds_dest
    };

    assign src1_busy = hz.src1_re && is_tracked(hz.src1) && busy_rd_vec[hz.src1];
    assign src2_busy = hz.src2_re && is_tracked(hz.src2) && busy_rd_vec[hz.src2];
    assign waw_full  = hz.dest_we && is_tracked(hz.dest) && full_vec[hz.dest];

    // Reset outranks everything, including the combinational handshake.
    assign ds_stall = !reset && hz.valid && (src1_busy || src2_busy || waw_full) && !pipe_flush;
    assign ds_issue = !reset && hz.valid && es_allowin && !ds_stall && !pipe_flush;

    assign inc_any = ds_issue && hz.dest_we && is_tracked(hz.dest);
    // A writeback in the cycle after a flush belongs to a squashed instruction.
    assign dec_any = ws_rf_we && is_tracked(ws_rf_waddr) && !flush_d;

    assign busy_vec[0]    = 1'b0;
    assign busy_rd_vec[0] = 1'b0;
    assign full_vec[0]    = 1'b0;
    assign err_vec[0]     = 1'b0;
    assign inc_vec[0]     = 1'b0;
    assign dec_vec[0]     = 1'b0;

    for (genvar i = 1; i < NREG; i++) begin : g_cell
        assign inc_vec[i] = inc_any && (hz.dest == GPR_AW'(i));
        assign dec_vec[i] = dec_any && (ws_rf_waddr == GPR_AW'(i));

        scbd_cnt_cell #(
            .CNT_W     (CNT_W),
            .WB_BYPASS (WB_BYPASS)
        ) u_cell (
            .clk     (clk),
            .reset   (reset),
            .clear   (pipe_flush),
            .inc     (inc_vec[i]),
            .dec     (dec_vec[i]),
            .busy    (busy_vec[i]),
            .busy_rd (busy_rd_vec[i]),
            .full    (full_vec[i]),
            .err     (err_vec[i])
        );
    end

    assign busy_regs = busy_vec;

    always_ff @(posedge clk) begin
        if (reset) begin
            flush_d      <= 1'b0;
            scbd_err     <= 1'b0;
            stall_cycles <= '0;
        end else begin
            flush_d <= pipe_flush;
            if (|err_vec) scbd_err <= 1'b1;
            if (ds_stall) stall_cycles <= stall_cycles + PERF_W'(1);
        end
    end

endmodule

// File: tb/tb_id_scoreboard_ctrl.sv
// Self-checking bench for id_scoreboard_ctrl: directed scenarios plus random traffic
// compared every cycle against an array-of-counts reference model.
module tb_id_scoreboard_ctrl;

    localparam int unsigned MAXC = 3;

    logic        clk = 1'b0;
    logic        reset;
    logic        ds_valid;
    logic        ds_src1_re;
    logic [4:0]  ds_src1;
    logic        ds_src2_re;
    logic [4:0]  ds_src2;
    logic        ds_dest_we;
    logic [4:0]  ds_dest;
    logic        es_allowin;
    logic        ws_rf_we;
    logic [4:0]  ws_rf_waddr;
    logic        pipe_flush;
    logic        ds_stall;
    logic        ds_issue;
    logic [31:0] busy_regs;
    logic        scbd_err;
    logic [31:0] stall_cycles;

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    int unsigned m_cnt [32];
    logic        m_err;
    logic [31:0] m_stall;
    logic        m_after_flush;

    always #5 clk = ~clk;

    id_scoreboard_ctrl #(
        .NREG   (32),
        .CNT_W  (2),
        .PERF_W (32)
    ) dut (
        .clk          (clk),
        .reset        (reset),
        .ds_valid     (ds_valid),
        .ds_src1_re   (ds_src1_re),
        .ds_src1      (ds_src1),
        .ds_src2_re   (ds_src2_re),
        .ds_src2      (ds_src2),
        .ds_dest_we   (ds_dest_we),
        .ds_dest      (ds_dest),
        .es_allowin   (es_allowin),
        .ws_rf_we     (ws_rf_we),
        .ws_rf_waddr  (ws_rf_waddr),
        .pipe_flush   (pipe_flush),
        .ds_stall     (ds_stall),
        .ds_issue     (ds_issue),
        .busy_regs    (busy_regs),
        .scbd_err     (scbd_err),
        .stall_cycles (stall_cycles)
    );

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic retiring_now(input logic [4:0] r);
        return ws_rf_we && ws_rf_waddr == r && r != 0 && !m_after_flush;
    endfunction

    function automatic logic reg_busy_for_read(input logic re, input logic [4:0] r);
        if (!re || r == 0 || m_cnt[r] == 0) return 1'b0;
`ifdef SCBD_WB_BYPASS_EN
        if (m_cnt[r] == 1 && retiring_now(r)) return 1'b0;
`endif
        return 1'b1;
    endfunction

    function automatic logic exp_stall();
        logic haz;
        haz = reg_busy_for_read(ds_src1_re, ds_src1) || reg_busy_for_read(ds_src2_re, ds_src2)
              || (ds_dest_we && ds_dest != 0 && m_cnt[ds_dest] == MAXC);
        return !reset && ds_valid && haz && !pipe_flush;
    endfunction

    function automatic logic [31:0] model_busy();
        logic [31:0] b;
        b = '0;
        for (int i = 1; i < 32; i++) b[i] = (m_cnt[i] != 0);
        return b;
    endfunction

    task automatic model_update(input logic st, input logic iss);
        logic inc;
        logic dec;
        if (reset) begin
            for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            m_err = 1'b0;
            m_stall = '0;
            m_after_flush = 1'b0;
        end else begin
            if (st) m_stall = m_stall + 32'd1;
            if (pipe_flush) begin
                for (int i = 0; i < 32; i++) m_cnt[i] = 0;
            end else begin
                inc = iss && ds_dest_we && ds_dest != 0;
                dec = ws_rf_we && ws_rf_waddr != 0 && !m_after_flush;
                if (!(inc && dec && ds_dest == ws_rf_waddr)) begin
                    if (inc) begin
                        if (m_cnt[ds_dest] == MAXC) m_err = 1'b1;
                        else m_cnt[ds_dest] = m_cnt[ds_dest] + 1;
                    end
                    if (dec) begin
                        if (m_cnt[ws_rf_waddr] == 0) m_err = 1'b1;
                        else m_cnt[ws_rf_waddr] = m_cnt[ws_rf_waddr] - 1;
                    end
                end
            end
            m_after_flush = pipe_flush;
        end
    endtask

    // Called right after a negedge with inputs already driven.
    task automatic step();
        logic st;
        logic iss;
        #1;
        st  = exp_stall();
        iss = !reset && ds_valid && es_allowin && !st && !pipe_flush;
        check("ds_stall", 64'(ds_stall), 64'(st));
        check("ds_issue", 64'(ds_issue), 64'(iss));
        check("busy_regs", 64'(busy_regs), 64'(model_busy()));
        check("scbd_err", 64'(scbd_err), 64'(m_err));
        check("stall_cycles", 64'(stall_cycles), 64'(m_stall));
        @(posedge clk);
        model_update(st, iss);
        @(negedge clk);
    endtask

    task automatic idle_inputs();
        ds_valid = 0; ds_src1_re = 0; ds_src1 = 0; ds_src2_re = 0; ds_src2 = 0;
        ds_dest_we = 0; ds_dest = 0; es_allowin = 0; ws_rf_we = 0; ws_rf_waddr = 0;
        pipe_flush = 0;
    endtask

    task automatic writer(input logic [4:0] d);
        idle_inputs();
        ds_valid = 1; ds_dest_we = 1; ds_dest = d; es_allowin = 1;
    endtask

    task automatic cleanup();
        idle_inputs();
        pipe_flush = 1;
        step();
        pipe_flush = 0;
        step();
    endtask

    task automatic random_cycle();
        int unsigned lst [16];
        int unsigned nb;
        idle_inputs();
        reset      = ($urandom_range(0, 299) == 0);
        ds_valid   = ($urandom_range(0, 3) != 0);
        ds_src1_re = $urandom_range(0, 1) == 1;
        ds_src1    = 5'($urandom_range(0, 15));
        ds_src2_re = $urandom_range(0, 1) == 1;
        ds_src2    = 5'($urandom_range(0, 15));
        ds_dest_we = ($urandom_range(0, 9) < 7);
        ds_dest    = 5'($urandom_range(0, 15));
        es_allowin = ($urandom_range(0, 9) < 8);
        pipe_flush = ($urandom_range(0, 39) == 0);
        ws_rf_we   = ($urandom_range(0, 9) < 4);
        nb = 0;
        for (int i = 1; i < 16; i++) if (m_cnt[i] != 0) begin lst[nb] = i; nb++; end
        if (nb != 0 && $urandom_range(0, 99) < 85)
            ws_rf_waddr = 5'(lst[$urandom_range(0, nb - 1)]);
        else
            ws_rf_waddr = 5'($urandom_range(0, 15));
        step();
    endtask

    initial begin
        for (int i = 0; i < 32; i++) m_cnt[i] = 0;
        m_err = 1'b0; m_stall = '0; m_after_flush = 1'b0;
        idle_inputs();
        reset = 1;
        @(negedge clk);
        step();
        step();
        reset = 0;
        check("reset_busy", 64'(busy_regs), 64'd0);
        check("reset_err", 64'(scbd_err), 64'd0);
        check("reset_stall_cnt", 64'(stall_cycles), 64'd0);

        // RAW on r4: stall until the retire lands.
        writer(4);
        #1 check("add_r4_issue", 64'(ds_issue), 64'd1);
        step();
        check("r4_busy", 64'(busy_regs[4]), 64'd1);
        writer(5); ds_src1_re = 1; ds_src1 = 4;
        step();
        #1 check("sub_stall", 64'(ds_stall), 64'd1);
        step();
        check("stall_cnt_2", 64'(stall_cycles), 64'd2);
        ws_rf_we = 1; ws_rf_waddr = 4;
`ifdef SCBD_WB_BYPASS_EN
        #1 check("retire_cycle_stall", 64'(ds_stall), 64'd0);
`else
        #1 check("retire_cycle_stall", 64'(ds_stall), 64'd1);
`endif
        step();
        ws_rf_we = 0;
        #1 check("after_retire_stall", 64'(ds_stall), 64'd0);
        check("after_retire_r4", 64'(busy_regs[4]), 64'd0);
        step();
`ifdef SCBD_WB_BYPASS_EN
        check("stall_cnt_total", 64'(stall_cycles), 64'd2);
`else
        check("stall_cnt_total", 64'(stall_cycles), 64'd3);
`endif
        cleanup();

        // Three writers fill r7; the fourth stalls without error.
        writer(7);
        step(); step(); step();
        #1 check("r7_busy", 64'(busy_regs[7]), 64'd1);
        check("waw_full_stall", 64'(ds_stall), 64'd1);
        check("waw_full_issue", 64'(ds_issue), 64'd0);
        step();
        check("waw_no_err", 64'(scbd_err), 64'd0);
        cleanup();

        // Issue and retire of r9 together leave its count unchanged.
        writer(9);
        step();
        ws_rf_we = 1; ws_rf_waddr = 9;
        step();
        idle_inputs();
        check("r9_held", 64'(busy_regs[9]), 64'd1);
        ws_rf_we = 1; ws_rf_waddr = 9;
        step();
        check("r9_drained", 64'(busy_regs[9]), 64'd0);
        check("r9_no_err", 64'(scbd_err), 64'd0);
        idle_inputs();

        // r0 is invisible to the scoreboard.
        writer(0); ds_src1_re = 1; ds_src2_re = 1;
        #1 check("r0_stall", 64'(ds_stall), 64'd0);
        check("r0_issue", 64'(ds_issue), 64'd1);
        step();
        check("r0_busy", 64'(busy_regs), 64'd0);

        // Flush clears everything and masks the following writeback.
        writer(5); step(); step();
        writer(6); step();
        idle_inputs();
        check("pre_flush_busy", 64'(busy_regs), 64'h60);
        pipe_flush = 1; ws_rf_we = 1; ws_rf_waddr = 5;
        step();
        pipe_flush = 0; ws_rf_waddr = 6;
        check("flush_busy", 64'(busy_regs), 64'd0);
        check("flush_err", 64'(scbd_err), 64'd0);
        step();
        idle_inputs();
        check("post_flush_err", 64'(scbd_err), 64'd0);
        step();

        // Underflow is sticky across a flush, cleared only by reset.
        ws_rf_we = 1; ws_rf_waddr = 12;
        step();
        idle_inputs();
        check("underflow_err", 64'(scbd_err), 64'd1);
        pipe_flush = 1; step();
        pipe_flush = 0; step();
        check("err_sticky", 64'(scbd_err), 64'd1);
        writer(3); reset = 1;
        #1 check("reset_issue", 64'(ds_issue), 64'd0);
        check("reset_stall", 64'(ds_stall), 64'd0);
        step();
        reset = 0;
        idle_inputs();
        check("rst2_busy", 64'(busy_regs), 64'd0);
        check("rst2_err", 64'(scbd_err), 64'd0);
        check("rst2_stall_cnt", 64'(stall_cycles), 64'd0);

        for (int n = 0; n < 3000; n++) random_cycle();
        reset = 0;
        idle_inputs();
        step();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule

// File: doc/id_scoreboard_ctrl.md
Name: id_scoreboard_ctrl

Overview:
- Register-hazard scheduler for the decode stage of the 5-stage pipeline.
- Tracks in-flight GPR writes between issue (ID→EX) and writeback (WB→RF).
- Produces the decode stall that gates ds_ready_go, plus issue permission.
- Has a pipeline-flush path and a stall-cycle performance counter.

Parameters:
- NREG, 32, number of architectural GPRs; r0 is never tracked.
- CNT_W, 2, width of each per-register pending counter; max in-flight writes per register = 2^CNT_W-1.
- PERF_W, 32, width of the stall-cycle counter.

Ports:
- clk  input  1  clock.
- reset  input  1  synchronous, active-high reset.
- ds_valid  input  1  decode stage holds a valid instruction.
- ds_src1_re  input  1  instruction reads src1.
- ds_src1  input  5  src1 register address.
- ds_src2_re  input  1  instruction reads src2.
- ds_src2  input  5  src2 register address.
- ds_dest_we  input  1  instruction writes a GPR.
- ds_dest  input  5  destination register address.
- es_allowin  input  1  execute stage accepts this cycle.
- ws_rf_we  input  1  writeback retires a GPR write this cycle.
- ws_rf_waddr  input  5  retired register address.
- pipe_flush  input  1  squash all in-flight instructions (exception/ertn).
- ds_stall  output  1  decode must not issue (hazard).
- ds_issue  output  1  issue handshake fires this cycle.
- busy_regs  output  NREG  bit i = counter i nonzero; bit 0 is always 0.
- scbd_err  output  1  sticky underflow/overflow error.
- stall_cycles  output  PERF_W  count of cycles with ds_valid && ds_stall.

Behaviour:
- State:
  - cnt[1..NREG-1] are CNT_W-bit counters.
  - scbd_err is a sticky flag.
  - stall_cycles is a counter.
- Reset: all cnt = 0, scbd_err = 0, stall_cycles = 0, so busy_regs = 0. ds_stall and ds_issue are combinational and equal 0 when ds_valid = 0.
- Hazard terms, all combinational:
  - src_busy = (ds_src1_re && ds_src1!=0 && cnt[ds_src1]!=0) || the same test for src2.
  - waw_full = ds_dest_we && ds_dest!=0 && cnt[ds_dest]==MAX.
- Outputs:
  - ds_stall = ds_valid && (src_busy || waw_full) && !pipe_flush.
  - ds_issue = ds_valid && es_allowin && !ds_stall && !pipe_flush.
- Update, taking effect at the next clock edge:
  - inc = ds_issue && ds_dest_we && ds_dest!=0.
  - dec = ws_rf_we && ws_rf_waddr!=0.
  - inc and dec on the same register: counter unchanged.
  - inc only: +1. dec only: −1.
  - dec on a counter already at 0: counter stays 0 and scbd_err is set.
  - inc on a counter at MAX cannot occur, because the block stalls first. If it does occur (ds_issue forced), the counter saturates and scbd_err is set.
- Flush:
  - pipe_flush = 1 clears every cnt to 0 at the next edge. It overrides inc and dec in the same cycle.
  - scbd_err and stall_cycles are unaffected by a flush.
  - For the cycle following the flush, dec is ignored, so a squashed writeback cannot underflow.
- Writes to r0 are never tracked. Reads of r0 are never busy.
- stall_cycles increments when ds_valid && ds_stall, and wraps at 2^PERF_W.
- Latency: a retire in cycle N unblocks a dependent instruction in cycle N+1 (without the optional feature).
- reset has priority over pipe_flush and over all updates.

Optional Feature:
- Macro: SCBD_WB_BYPASS_EN.
- Defined: when computing src_busy, a register being retired this cycle counts as non-busy if its counter is exactly 1. A dependent instruction can then issue in the same cycle as the writeback; the RF read path must forward ws data.
- Undefined: src_busy uses registered counters only, giving a one-cycle retire-to-issue bubble.
- waw_full is unaffected in both cases.

Decomposition:
- Shared package / mycpu.vh holds:
  - the GPR address width (5) and NREG;
  - the CNT_W default;
  - the r0 constant;
  - a bus-width define for a packed ds-to-scoreboard hazard bus.
- One natural sub-module, scbd_cnt_cell: a single register's saturating up/down counter with clear, inc, dec, busy and err outputs, instantiated NREG-1 times.

Test Plan:
- Issue `add r4` (dest_we=1), then `sub` reading r4 the next cycle with no retire → ds_stall=1 and stall_cycles increments each cycle. Retire r4 with ws_rf_we=1 → cnt[4]=0, ds_stall drops the next cycle, or the same cycle with SCBD_WB_BYPASS_EN.
- Three back-to-back writers to r7 with no retire (MAX=3) → busy_regs[7]=1. A fourth writer to r7 gets ds_stall=1 and scbd_err stays 0.
- Issue a writer to r9 and retire r9 in the same cycle while cnt[9]=1 → cnt[9] stays 1.
- Instruction with dest r0 and src r0 → ds_stall=0, busy_regs[0]=0, and no counter changes.
- Load cnt[5]=2 and cnt[6]=1, then pulse pipe_flush together with a retire of r5 → all counters 0 and scbd_err=0. A retire of r6 the next cycle is ignored and scbd_err stays 0.
- Retire r12 while cnt[12]=0 → scbd_err=1 and stays set until reset. Asserting reset together with ds_valid → all outputs and counters are 0.
